tensor_core_4x4: RTL and testbench

Fixed-size matrix-multiply engine for the CPU's tensor path. It computes OUT = A x B on two DIM x DIM signed matrices that the tensor register file presents in parallel. On completion it raises a one-cycle done pulse, and the register file bulk-writes OUT back into matrix slot 0. A start is triggered by the TENSOR_CORE_OPERATE instruction; any tensor register-file write aborts a running computation.

---
 rtl/tensor_core_pkg.sv | 21 ++
 rtl/tensor_core_mac_lane.sv | 31 +++
 rtl/tensor_core_4x4.sv | 106 ++++++++++
 tb/tb_tensor_core_4x4.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// Shared constants, element/matrix types and FSM states for the 4x4 tensor core.
// Matrices are packed [row][col] so they travel across ports as a single bus.
package tensor_core_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DIM        = 4;
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + 2;
  localparam int K_WIDTH    = $clog2(DIM + 1);
  localparam int IDX_WIDTH  = $clog2(DIM);

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [DIM-1:0][DIM-1:0] matrix_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE,
    WAIT_RELEASE
  } tc_state_t;

endpackage

// File: rtl/tensor_core_mac_lane.sv
// One multiply-accumulate lane: acc += a*b with a full-precision signed product.
// The accumulator is wide enough that DIM products never overflow.
module tensor_core_mac_lane
  import tensor_core_pkg::*;
(
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        clear,
  input  logic                        enable,
  input  elem_t                       operand_a,
  input  elem_t                       operand_b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;

  assign product     = operand_a * operand_b;
  assign product_ext = product;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/tensor_core_4x4.sv
// DIM x DIM signed matrix multiply: one k-step per cycle across all lanes, then a
// registered low-byte result and a one-cycle done pulse (one pulse per start assertion).
module tensor_core_4x4
  import tensor_core_pkg::*;
(
  input  logic    clock_in,
  input  logic    reset_in,
  input  logic    should_start_tensor_core,
  input  logic    tensor_core_register_file_write_enable,
  input  matrix_t tensor_core_input1,
  input  matrix_t tensor_core_input2,
  output matrix_t tensor_core_output,
  output logic    is_done_with_calculation
);

  tc_state_t state, next_state;

  logic [K_WIDTH-1:0]   k;
  logic [IDX_WIDTH-1:0] k_sel;
  matrix_t              a_reg, b_reg;
  logic                 capture, mac_en, load_out;

  logic signed [ACC_WIDTH-1:0] acc [DIM][DIM];
  logic [DIM*DIM-1:0]          unused_acc_hi;

  assign k_sel                    = k[IDX_WIDTH-1:0];
  assign is_done_with_calculation = (state == DONE);

  // k runs 0..DIM-1 accumulating; the extra k==DIM cycle latches the finished sums.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    mac_en     = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (should_start_tensor_core && !tensor_core_register_file_write_enable) begin
          next_state = COMPUTE;
          capture    = 1'b1;
        end
      end
      COMPUTE: begin
        if (tensor_core_register_file_write_enable) begin
          next_state = IDLE;
        end else if (k == K_WIDTH'(DIM)) begin
          next_state = DONE;
          load_out   = 1'b1;
        end else begin
          mac_en = 1'b1;
        end
      end
      DONE: begin
        next_state = should_start_tensor_core ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (!should_start_tensor_core) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state              <= IDLE;
      k                  <= '0;
      a_reg              <= '0;
      b_reg              <= '0;
      tensor_core_output <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        a_reg <= tensor_core_input1;
        b_reg <= tensor_core_input2;
        k     <= '0;
      end else if (mac_en) begin
        k <= k + 1'b1;
      end
      if (load_out) begin
        for (int i = 0; i < DIM; i++) begin
          for (int j = 0; j < DIM; j++) begin
            tensor_core_output[i][j] <= acc[i][j][DATA_WIDTH-1:0];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      tensor_core_mac_lane u_lane (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .clear     (capture),
        .enable    (mac_en),
        .operand_a (a_reg[i][k_sel]),
        .operand_b (b_reg[k_sel][j]),
        .acc       (acc[i][j])
      );
      // Upper accumulator bits are dropped by the two's-complement wrap on output.
      assign unused_acc_hi[i*DIM+j] = ^acc[i][j][ACC_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_tensor_core_4x4.sv
// Scoreboard bench for tensor_core_4x4: expected products are queued at start and
// popped whenever the core pulses done.
module tb_tensor_core_4x4;
  import tensor_core_pkg::*;

  logic    clock_in;
  logic    reset_in;
  logic    should_start_tensor_core;
  logic    tensor_core_register_file_write_enable;
  matrix_t tensor_core_input1;
  matrix_t tensor_core_input2;
  matrix_t tensor_core_output;
  logic    is_done_with_calculation;

  int      checkCount = 0;
  int      passCount  = 0;
  int      doneCount  = 0;
  matrix_t expQ[$];
  matrix_t lastResult;

  tensor_core_4x4 dut (
    .clock_in                               (clock_in),
    .reset_in                               (reset_in),
    .should_start_tensor_core               (should_start_tensor_core),
    .tensor_core_register_file_write_enable (tensor_core_register_file_write_enable),
    .tensor_core_input1                     (tensor_core_input1),
    .tensor_core_input2                     (tensor_core_input2),
    .tensor_core_output                     (tensor_core_output),
    .is_done_with_calculation               (is_done_with_calculation)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string tag,
                             input logic [$bits(matrix_t)-1:0] actual,
                             input logic [$bits(matrix_t)-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  function automatic matrix_t matMul(input matrix_t a, input matrix_t b);
    matrix_t r;
    elem_t   ea, eb;
    int      sum;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        sum = 0;
        for (int k = 0; k < DIM; k++) begin
          ea = a[i][k];
          eb = b[k][j];
          sum += int'(ea) * int'(eb);
        end
        r[i][j] = sum[DATA_WIDTH-1:0];
      end
    end
    return r;
  endfunction

  function automatic matrix_t fillConst(input int v);
    matrix_t r;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r[i][j] = v[DATA_WIDTH-1:0];
    return r;
  endfunction

  function automatic matrix_t identity();
    matrix_t r;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r[i][j] = (i == j) ? elem_t'(1) : elem_t'(0);
    return r;
  endfunction

  function automatic matrix_t ramp();
    matrix_t r;
    int      v;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        v = 4*i + j;
        r[i][j] = v[DATA_WIDTH-1:0];
      end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock_in) begin
    if (is_done_with_calculation) begin
      doneCount++;
      if (expQ.size() == 0) checkOutput("unexpected done", 1, 0);
      else checkOutput("scoreboard out", tensor_core_output, expQ.pop_front());
    end
  end

  task automatic applyStimulus(input string tag, input matrix_t a, input matrix_t b,
                               input int hold);
    int   n;
    int   startDone;
    bit   seen;
    n         = 0;
    seen      = 0;
    startDone = doneCount;
    @(negedge clock_in);
    tensor_core_input1       = a;
    tensor_core_input2       = b;
    should_start_tensor_core = 1'b1;
    lastResult               = matMul(a, b);
    expQ.push_back(lastResult);
    while (!(seen && n >= hold + 2) && n < 60) begin
      @(negedge clock_in);
      n++;
      if (is_done_with_calculation && !seen) begin
        seen = 1;
        checkOutput({tag, " latency"}, n, 6);
      end
      if (n == hold) should_start_tensor_core = 1'b0;
    end
    should_start_tensor_core = 1'b0;
    if (!seen) checkOutput({tag, " done timeout"}, 0, 1);
    repeat (4) @(negedge clock_in);
    checkOutput({tag, " done pulses"}, doneCount - startDone, 1);
  endtask

  initial begin
    int startDone;
    reset_in                               = 1'b0;
    should_start_tensor_core               = 1'b0;
    tensor_core_register_file_write_enable = 1'b0;
    tensor_core_input1                     = '0;
    tensor_core_input2                     = '0;
    lastResult                             = '0;
    repeat (2) @(negedge clock_in);
    checkOutput("reset out", tensor_core_output, '0);
    checkOutput("reset done", is_done_with_calculation, 0);
    reset_in = 1'b1;
    @(negedge clock_in);

    applyStimulus("identity", identity(), ramp(), 1);
    checkOutput("identity equals B", tensor_core_output, ramp());

    applyStimulus("twos", fillConst(2), fillConst(2), 1);
    checkOutput("twos const", tensor_core_output, fillConst(16));

    applyStimulus("neg", fillConst(-1), fillConst(3), 1);
    checkOutput("neg const", tensor_core_output, fillConst(-12));

    applyStimulus("wrap", fillConst(127), fillConst(127), 1);
    checkOutput("wrap const", tensor_core_output, fillConst(4));

    applyStimulus("held start", ramp(), identity(), 20);
    applyStimulus("restart", ramp(), ramp(), 1);

    // Abort with a register-file write while k==2.
    startDone = doneCount;
    @(negedge clock_in);
    tensor_core_input1       = fillConst(5);
    tensor_core_input2       = fillConst(7);
    should_start_tensor_core = 1'b1;
    @(negedge clock_in);
    should_start_tensor_core = 1'b0;
    repeat (2) @(negedge clock_in);
    tensor_core_register_file_write_enable = 1'b1;
    @(negedge clock_in);
    tensor_core_register_file_write_enable = 1'b0;
    repeat (10) @(negedge clock_in);
    checkOutput("abort no done", doneCount - startDone, 0);
    checkOutput("abort out held", tensor_core_output, lastResult);
    applyStimulus("after abort", fillConst(-3), ramp(), 1);

    // Asynchronous reset in the middle of COMPUTE.
    startDone = doneCount;
    @(negedge clock_in);
    tensor_core_input1       = ramp();
    tensor_core_input2       = fillConst(9);
    should_start_tensor_core = 1'b1;
    @(negedge clock_in);
    should_start_tensor_core = 1'b0;
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;
    #1;
    checkOutput("midreset out", tensor_core_output, '0);
    checkOutput("midreset done", is_done_with_calculation, 0);
    @(negedge clock_in);
    reset_in = 1'b1;
    repeat (8) @(negedge clock_in);
    checkOutput("midreset no done", doneCount - startDone, 0);
    checkOutput("midreset out held", tensor_core_output, '0);
    applyStimulus("after reset", ramp(), fillConst(-2), 1);

    repeat (4) @(negedge clock_in);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
